// File: rtl/pid_hdng_ctrl.sv
// rtl/pid_hdng_ctrl.sv - heading PID controller producing saturated differential wheel speeds
//
// Three-stage pipeline:
//   stage 0 : heading error, wrapped and saturated to ERR_W, registered
//   stage 1 : P and D products, integrator update, at-heading debounce
//   stage 2 : correction sum, left/right speed saturation, spd_vld_o pulse
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous active-high reset
//   moving_i       controller enable; low clears the integrator, history and outputs
//   hdng_vld_i     one-cycle strobe marking a new actual-heading sample
//   dsrd_hdng_i    desired heading (HDNG_W, two's-complement wrap)
//   actl_hdng_i    actual heading (HDNG_W, two's-complement wrap)
//   frwrd_spd_i    unsigned forward speed (SPD_W-1)
//   kp_i           unsigned P gain, sampled in stage 1
//   kd_i           unsigned D gain, sampled in stage 1
//   lft_spd_o      signed left wheel speed, registered
//   rght_spd_o     signed right wheel speed, registered
//   spd_vld_o      one-cycle pulse when the speeds update
//   at_hdng_o      debounced heading-reached flag
//
// Optional feature macro: PID_INT_CLAMP_EN
//   defined   : an overflowing integrator update saturates to the signed INT_W limit
//   undefined : an overflowing integrator update leaves the integrator unchanged

module pid_hdng_ctrl #(
    parameter int HDNG_W     = 12,
    parameter int ERR_W      = 10,
    parameter int SPD_W      = 12,
    parameter int INT_W      = 16,
    parameter int I_SHIFT    = 4,
    parameter int D_W        = 8,
    parameter int AT_THRESH  = 30,
    parameter int SETTLE_CNT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    moving_i,
    input  logic                    hdng_vld_i,
    input  logic [HDNG_W-1:0]       dsrd_hdng_i,
    input  logic [HDNG_W-1:0]       actl_hdng_i,
    input  logic [SPD_W-2:0]        frwrd_spd_i,
    input  logic [3:0]              kp_i,
    input  logic [4:0]              kd_i,
    output logic signed [SPD_W-1:0] lft_spd_o,
    output logic signed [SPD_W-1:0] rght_spd_o,
    output logic                    spd_vld_o,
    output logic                    at_hdng_o
);

    localparam int P_W   = ERR_W + 5;     // signed err x 4-bit unsigned gain
    localparam int DP_W  = D_W + 6;       // signed diff x 5-bit unsigned gain
    localparam int SUM_W = ERR_W + 7;
    localparam int LS_W  = ((SUM_W > SPD_W) ? SUM_W : SPD_W) + 1;
    localparam int CNT_W = $clog2(SETTLE_CNT + 1);

    localparam logic [ERR_W-1:0] ERR_MAX = {1'b0, {(ERR_W-1){1'b1}}};
    localparam logic [ERR_W-1:0] ERR_MIN = {1'b1, {(ERR_W-1){1'b0}}};
    localparam logic [D_W-1:0]   DIF_MAX = {1'b0, {(D_W-1){1'b1}}};
    localparam logic [D_W-1:0]   DIF_MIN = {1'b1, {(D_W-1){1'b0}}};
    localparam logic [SPD_W-1:0] SPD_MAX = {1'b0, {(SPD_W-1){1'b1}}};
    localparam logic [SPD_W-1:0] SPD_MIN = {1'b1, {(SPD_W-1){1'b0}}};
`ifdef PID_INT_CLAMP_EN
    localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
    localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};
`endif
    localparam logic [CNT_W-1:0] SETTLE  = CNT_W'(SETTLE_CNT);

    // pipeline state
    logic                    v1_q, v2_q;
    logic signed [ERR_W-1:0] err_q;
    logic signed [ERR_W-1:0] prev_err_q;
    logic signed [P_W-1:0]   p_q;
    logic signed [DP_W-1:0]  d_q;
    logic signed [INT_W-1:0] integ_q;
    logic [CNT_W-1:0]        cnt_q;
    logic signed [SPD_W-1:0] lft_q, rght_q;
    logic                    spd_vld_q, at_hdng_q;

    // stage 0 combinational
    logic [HDNG_W-1:0]       raw_err;
    logic                    err_fits;
    logic [ERR_W-1:0]        err_d;

    // stage 1 combinational
    logic [ERR_W:0]          diff_full;
    logic                    diff_fits;
    logic signed [D_W-1:0]   diff_sat;
    logic signed [P_W-1:0]   p_d;
    logic signed [DP_W-1:0]  d_d;
    logic [INT_W-1:0]        acc;
    logic                    int_ovf;
    logic signed [INT_W-1:0] integ_d;
    logic signed [31:0]      err_int;
    logic                    in_band;
    logic [CNT_W-1:0]        cnt_d;

    // stage 2 combinational
    logic signed [INT_W-1:0] i_term;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] corr;
    logic [LS_W-1:0]         frwrd_ext;
    logic [LS_W-1:0]         lft_full, rght_full;
    logic                    lft_fits, rght_fits;
    logic [SPD_W-1:0]        lft_d, rght_d;

    always_comb begin
        // Subtraction in HDNG_W bits gives the modulo-2^HDNG_W wrap for free.
        raw_err  = actl_hdng_i - dsrd_hdng_i;
        // The value fits in ERR_W when all bits from the ERR_W sign bit up agree.
        err_fits = (&raw_err[HDNG_W-1:ERR_W-1]) | ~(|raw_err[HDNG_W-1:ERR_W-1]);
        err_d    = err_fits ? raw_err[ERR_W-1:0] : (raw_err[HDNG_W-1] ? ERR_MIN : ERR_MAX);
    end

    always_comb begin
        diff_full = {err_q[ERR_W-1], err_q} - {prev_err_q[ERR_W-1], prev_err_q};
        diff_fits = (&diff_full[ERR_W:D_W-1]) | ~(|diff_full[ERR_W:D_W-1]);
        diff_sat  = diff_fits ? diff_full[D_W-1:0] : (diff_full[ERR_W] ? DIF_MIN : DIF_MAX);

        p_d = P_W'(err_q) * $signed(P_W'({1'b0, kp_i}));
        d_d = DP_W'(diff_sat) * $signed(DP_W'({1'b0, kd_i}));

        // Overflow: both addends share a sign that the sum does not.
        acc     = integ_q + INT_W'(err_q);
        int_ovf = (integ_q[INT_W-1] == err_q[ERR_W-1]) && (acc[INT_W-1] != integ_q[INT_W-1]);
`ifdef PID_INT_CLAMP_EN
        integ_d = int_ovf ? (integ_q[INT_W-1] ? INT_MIN : INT_MAX) : acc;
`else
        integ_d = int_ovf ? integ_q : acc;
`endif

        err_int = 32'(err_q);
        in_band = (err_int < AT_THRESH) && (err_int > -AT_THRESH);
        if (!in_band) begin
            cnt_d = '0;
        end else if (cnt_q == SETTLE) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        i_term    = integ_q >>> I_SHIFT;
        sum       = SUM_W'(p_q) + SUM_W'(i_term) + SUM_W'(d_q);
        corr      = sum >>> 3;
        frwrd_ext = LS_W'({1'b0, frwrd_spd_i});
        lft_full  = frwrd_ext + LS_W'(corr);
        rght_full = frwrd_ext - LS_W'(corr);
        lft_fits  = (&lft_full[LS_W-1:SPD_W-1]) | ~(|lft_full[LS_W-1:SPD_W-1]);
        rght_fits = (&rght_full[LS_W-1:SPD_W-1]) | ~(|rght_full[LS_W-1:SPD_W-1]);
        lft_d     = lft_fits ? lft_full[SPD_W-1:0] : (lft_full[LS_W-1] ? SPD_MIN : SPD_MAX);
        rght_d    = rght_fits ? rght_full[SPD_W-1:0] : (rght_full[LS_W-1] ? SPD_MIN : SPD_MAX);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            err_q      <= '0;
            prev_err_q <= '0;
            p_q        <= '0;
            d_q        <= '0;
            integ_q    <= '0;
            cnt_q      <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
            spd_vld_q  <= 1'b0;
            at_hdng_q  <= 1'b0;
        end else if (!moving_i) begin
            // Disabled: drop in-flight samples and forget all history.
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            prev_err_q <= '0;
            integ_q    <= '0;
            cnt_q      <= '0;
            lft_q      <= '0;
            rght_q     <= '0;
            spd_vld_q  <= 1'b0;
            at_hdng_q  <= 1'b0;
        end else begin
            v1_q <= hdng_vld_i;
            if (hdng_vld_i) begin
                err_q <= err_d;
            end

            v2_q <= v1_q;
            if (v1_q) begin
                p_q        <= p_d;
                d_q        <= d_d;
                integ_q    <= integ_d;
                prev_err_q <= err_q;
                cnt_q      <= cnt_d;
                at_hdng_q  <= (cnt_d == SETTLE);
            end

            // Stage 2 reads integ_q after this sample's update; a younger sample
            // updating integ_q on the same edge is not yet visible here.
            spd_vld_q <= v2_q;
            if (v2_q) begin
                lft_q  <= lft_d;
                rght_q <= rght_d;
            end
        end
    end

    assign lft_spd_o  = lft_q;
    assign rght_spd_o = rght_q;
    assign spd_vld_o  = spd_vld_q;
    assign at_hdng_o  = at_hdng_q;

endmodule
